// File: rtl/ray_pair_feeder_if.sv
// Handshake and data bundle between a distance-sample source and the pair feeder.
// Sample side (start, dist_valid, dist_in) flows in; pair side (a, b, en) flows out.
// The master drives samples and watches status; the slave is the feeder itself.
interface ray_pair_feeder_if #(
  parameter int DW = 16
);
  logic          start;
  logic          dist_valid;
  logic [DW-1:0] dist_in;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          en;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  modport master (
    output start, dist_valid, dist_in,
    input  a, b, en, busy, frame_done, overrun
  );

  modport slave (
    input  start, dist_valid, dist_in,
    output a, b, en, busy, frame_done, overrun
  );
endinterface

// File: rtl/ray_pair_feeder.sv
// Turns a revolution of N_RAYS distance samples into N_RAYS adjacent (a,b) pairs, closing the ring.
// Latency: 1 clock from an accepted sample to its en strobe; the closing pair follows the last one.
// No backpressure: gaps stall the stream; samples arriving during the closing cycles are dropped and flagged.
module ray_pair_feeder #(
  parameter int N_RAYS = 64,
  parameter int DW     = 16
) (
  input logic            clk,
  input logic            rst,
  ray_pair_feeder_if.slave bus
);

  localparam int CW = $clog2(N_RAYS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    STREAM = 3'd2,
    CLOSE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] first_q;
  logic [DW-1:0] prev_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic          en_q;
  logic          busy_q;
  logic          frame_done_q;
  logic          overrun_q;

  // Revolution sequencer: all outputs are registered here alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      first_q      <= '0;
      prev_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      en_q         <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // busy_q is still high during the frame_done cycle that follows DONE;
          // a start seen then belongs to a busy block and is ignored.
          if (bus.start && !busy_q) begin
            state_q   <= FIRST;
            busy_q    <= 1'b1;
            overrun_q <= 1'b0;
          end else begin
            busy_q <= 1'b0;
          end
        end
        FIRST: begin
          if (bus.dist_valid) begin
            first_q <= bus.dist_in;
            prev_q  <= bus.dist_in;
            cnt_q   <= CW'(1);
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (bus.dist_valid) begin
            a_q    <= prev_q;
            b_q    <= bus.dist_in;
            en_q   <= 1'b1;
            prev_q <= bus.dist_in;
            cnt_q  <= cnt_q + CW'(1);
            if (cnt_q == CW'(N_RAYS - 1)) begin
              state_q <= CLOSE;
            end
          end
        end
        CLOSE: begin
          // Wrap-around pair: last sample against the first one.
          a_q     <= prev_q;
          b_q     <= first_q;
          en_q    <= 1'b1;
          state_q <= DONE;
          if (bus.dist_valid) begin
            overrun_q <= 1'b1;
          end
        end
        DONE: begin
          frame_done_q <= 1'b1;
          state_q      <= IDLE;
          if (bus.dist_valid) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.en         = en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_ray_pair_feeder.sv
// Directed bench for ray_pair_feeder: three instances (N_RAYS = 4, 64, 2) sharing clock and reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected pairs are written out by hand from the sample sequences each scenario drives.
module tb_ray_pair_feeder;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ray_pair_feeder_if #(.DW(DW)) if4 ();
  ray_pair_feeder_if #(.DW(DW)) if64 ();
  ray_pair_feeder_if #(.DW(DW)) if2 ();

  ray_pair_feeder #(.N_RAYS(4),  .DW(DW)) u4  (.clk(clk), .rst(rst), .bus(if4));
  ray_pair_feeder #(.N_RAYS(64), .DW(DW)) u64 (.clk(clk), .rst(rst), .bus(if64));
  ray_pair_feeder #(.N_RAYS(2),  .DW(DW)) u2  (.clk(clk), .rst(rst), .bus(if2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    if4.start = 1'b0;  if4.dist_valid = 1'b0;  if4.dist_in = '0;
    if64.start = 1'b0; if64.dist_valid = 1'b0; if64.dist_in = '0;
    if2.start = 1'b0;  if2.dist_valid = 1'b0;  if2.dist_in = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #2 rst = 1'b1;
    #2;
    n_tests++;
    if ({if4.a, if4.b, if4.en, if4.busy, if4.frame_done, if4.overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_u4: got a=%h b=%h en=%b busy=%b fd=%b ov=%b, want all 0",
               if4.a, if4.b, if4.en, if4.busy, if4.frame_done, if4.overrun);
    end
    n_tests++;
    if ({if64.a, if64.b, if64.en, if64.busy, if64.frame_done, if64.overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_u64: got a=%h b=%h en=%b busy=%b fd=%b ov=%b, want all 0",
               if64.a, if64.b, if64.en, if64.busy, if64.frame_done, if64.overrun);
    end
    n_tests++;
    if ({if2.a, if2.b, if2.en, if2.busy, if2.frame_done, if2.overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_u2: got a=%h b=%h en=%b busy=%b fd=%b ov=%b, want all 0",
               if2.a, if2.b, if2.en, if2.busy, if2.frame_done, if2.overrun);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  // N_RAYS=4, samples 10,20,30,40 back to back.
  task automatic test_basic;
    logic [DW-1:0] smp [4];
    smp[0] = 16'd10; smp[1] = 16'd20; smp[2] = 16'd30; smp[3] = 16'd40;
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    n_tests++;
    if (if4.busy !== 1'b1 || if4.en !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_first: busy=%b en=%b, want busy=1 en=0", if4.busy, if4.en);
    end
    for (int i = 0; i < 4; i++) begin
      if4.dist_valid = 1'b1;
      if4.dist_in    = smp[i];
      tick();
      n_tests++;
      if (i == 0) begin
        if (if4.en !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_no_en_first: en=%b, want 0", if4.en);
        end
      end else if (if4.en !== 1'b1 || if4.a !== smp[i-1] || if4.b !== smp[i] || if4.frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_pair%0d: en=%b a=%0d b=%0d fd=%b, want en=1 a=%0d b=%0d fd=0",
                 i, if4.en, if4.a, if4.b, if4.frame_done, smp[i-1], smp[i]);
      end
    end
    if4.dist_valid = 1'b0;
    tick();
    n_tests++;
    if (if4.en !== 1'b1 || if4.a !== 16'd40 || if4.b !== 16'd10 || if4.frame_done !== 1'b0 || if4.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_close: en=%b a=%0d b=%0d fd=%b busy=%b, want en=1 a=40 b=10 fd=0 busy=1",
               if4.en, if4.a, if4.b, if4.frame_done, if4.busy);
    end
    tick();
    n_tests++;
    if (if4.en !== 1'b0 || if4.frame_done !== 1'b1 || if4.busy !== 1'b1 || if4.a !== 16'd40 || if4.b !== 16'd10) begin
      n_fail++;
      $display("FAIL basic_done: en=%b fd=%b busy=%b a=%0d b=%0d, want en=0 fd=1 busy=1 a=40 b=10",
               if4.en, if4.frame_done, if4.busy, if4.a, if4.b);
    end
    tick();
    n_tests++;
    if (if4.frame_done !== 1'b0 || if4.busy !== 1'b0 || if4.en !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: fd=%b busy=%b en=%b, want 0 0 0", if4.frame_done, if4.busy, if4.en);
    end
  endtask

  // N_RAYS=64 with 0..3-cycle gaps; sample i is i*1000+7.
  task automatic test_gaps;
    int en_cnt = 0;
    int gap;
    int bad_gap = 0;
    int bad_pair = 0;
    if64.start = 1'b1;
    tick();
    if64.start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      gap = (i * 3 + 1) % 4;
      for (int g = 0; g < gap; g++) begin
        if64.dist_valid = 1'b0;
        tick();
        if (if64.en === 1'b1) begin
          en_cnt++;
          bad_gap++;
        end
      end
      if64.dist_valid = 1'b1;
      if64.dist_in    = 16'(i * 1000 + 7);
      tick();
      if (if64.en === 1'b1) en_cnt++;
      if (i == 0) begin
        if (if64.en !== 1'b0) bad_pair++;
      end else if (if64.en !== 1'b1 || if64.a !== 16'((i - 1) * 1000 + 7) || if64.b !== 16'(i * 1000 + 7)) begin
        bad_pair++;
        if (bad_pair < 4)
          $display("FAIL gaps_pair%0d: en=%b a=%0d b=%0d, want en=1 a=%0d b=%0d",
                   i, if64.en, if64.a, if64.b, (i - 1) * 1000 + 7, i * 1000 + 7);
      end
    end
    n_tests++;
    if (bad_pair != 0) begin
      n_fail++;
      $display("FAIL gaps_pairs: %0d bad pairs, want 0", bad_pair);
    end
    n_tests++;
    if (bad_gap != 0) begin
      n_fail++;
      $display("FAIL gaps_stall: %0d en pulses during gaps, want 0", bad_gap);
    end
    if64.dist_valid = 1'b0;
    tick();
    if (if64.en === 1'b1) en_cnt++;
    n_tests++;
    if (if64.en !== 1'b1 || if64.a !== 16'd63007 || if64.b !== 16'd7) begin
      n_fail++;
      $display("FAIL gaps_close: en=%b a=%0d b=%0d, want en=1 a=63007 b=7", if64.en, if64.a, if64.b);
    end
    tick();
    if (if64.en === 1'b1) en_cnt++;
    n_tests++;
    if (if64.frame_done !== 1'b1 || if64.en !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_done: fd=%b en=%b, want fd=1 en=0", if64.frame_done, if64.en);
    end
    n_tests++;
    if (en_cnt != 64) begin
      n_fail++;
      $display("FAIL gaps_en_count: got %0d, want 64", en_cnt);
    end
    tick();
  endtask

  // N_RAYS=4, samples 1..4, extra sample during CLOSE sets overrun.
  task automatic test_overrun;
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if4.dist_valid = 1'b1;
      if4.dist_in    = 16'(i);
      tick();
    end
    n_tests++;
    if (if4.en !== 1'b1 || if4.a !== 16'd3 || if4.b !== 16'd4 || if4.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_last_pair: en=%b a=%0d b=%0d ov=%b, want en=1 a=3 b=4 ov=0",
               if4.en, if4.a, if4.b, if4.overrun);
    end
    if4.dist_in = 16'd99;
    tick();
    if4.dist_valid = 1'b0;
    n_tests++;
    if (if4.en !== 1'b1 || if4.a !== 16'd4 || if4.b !== 16'd1 || if4.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_close: en=%b a=%0d b=%0d ov=%b, want en=1 a=4 b=1 ov=1",
               if4.en, if4.a, if4.b, if4.overrun);
    end
    tick();
    tick();
    n_tests++;
    if (if4.overrun !== 1'b1 || if4.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_sticky: ov=%b busy=%b, want ov=1 busy=0", if4.overrun, if4.busy);
    end
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    n_tests++;
    if (if4.overrun !== 1'b0 || if4.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_cleared: ov=%b busy=%b, want ov=0 busy=1", if4.overrun, if4.busy);
    end
  endtask

  // Samples in IDLE are ignored; start mid-revolution is ignored.
  task automatic test_start_ignored;
    logic [DW-1:0] smp [4];
    int bad = 0;
    smp[0] = 16'd11; smp[1] = 16'd12; smp[2] = 16'd13; smp[3] = 16'd14;
    if4.dist_valid = 1'b1;
    if4.dist_in    = 16'd77;
    tick();
    tick();
    if4.dist_valid = 1'b0;
    n_tests++;
    if (if4.en !== 1'b0 || if4.overrun !== 1'b0 || if4.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignore: en=%b ov=%b busy=%b, want 0 0 0", if4.en, if4.overrun, if4.busy);
    end
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        if4.dist_valid = 1'b0;
        if4.start      = 1'b1;
        tick();
        if4.start = 1'b0;
        if (if4.en !== 1'b0 || if4.busy !== 1'b1) bad++;
      end
      if4.dist_valid = 1'b1;
      if4.dist_in    = smp[i];
      tick();
      if (i > 0 && (if4.en !== 1'b1 || if4.a !== smp[i-1] || if4.b !== smp[i])) begin
        bad++;
        $display("FAIL restart_pair%0d: en=%b a=%0d b=%0d, want en=1 a=%0d b=%0d",
                 i, if4.en, if4.a, if4.b, smp[i-1], smp[i]);
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL restart_ignored: %0d bad cycles, want 0", bad);
    end
    if4.dist_valid = 1'b0;
    tick();
    n_tests++;
    if (if4.en !== 1'b1 || if4.a !== 16'd14 || if4.b !== 16'd11) begin
      n_fail++;
      $display("FAIL restart_close: en=%b a=%0d b=%0d, want en=1 a=14 b=11", if4.en, if4.a, if4.b);
    end
    tick();
    n_tests++;
    if (if4.frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_done: fd=%b, want 1", if4.frame_done);
    end
    tick();
  endtask

  // Async reset after the 3rd of 64 samples, then a fresh N_RAYS=2 revolution.
  task automatic test_async_reset;
    int fd_seen = 0;
    if64.start = 1'b1;
    tick();
    if64.start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if64.dist_valid = 1'b1;
      if64.dist_in    = 16'(i);
      tick();
    end
    if64.dist_valid = 1'b0;
    n_tests++;
    if (if64.en !== 1'b1 || if64.a !== 16'd2 || if64.b !== 16'd3) begin
      n_fail++;
      $display("FAIL arst_pre: en=%b a=%0d b=%0d, want en=1 a=2 b=3", if64.en, if64.a, if64.b);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({if64.a, if64.b, if64.en, if64.busy, if64.frame_done, if64.overrun} !== '0) begin
      n_fail++;
      $display("FAIL arst_clear: a=%h b=%h en=%b busy=%b fd=%b ov=%b, want all 0",
               if64.a, if64.b, if64.en, if64.busy, if64.frame_done, if64.overrun);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if64.dist_valid = 1'b1;
      if64.dist_in    = 16'd50;
      tick();
      if (if64.frame_done === 1'b1 || if64.en === 1'b1 || if64.busy === 1'b1) fd_seen++;
    end
    if64.dist_valid = 1'b0;
    n_tests++;
    if (fd_seen != 0) begin
      n_fail++;
      $display("FAIL arst_needs_start: %0d active cycles, want 0", fd_seen);
    end
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    if2.dist_valid = 1'b1;
    if2.dist_in    = 16'd5;
    tick();
    if2.dist_in = 16'd6;
    tick();
    if2.dist_valid = 1'b0;
    n_tests++;
    if (if2.en !== 1'b1 || if2.a !== 16'd5 || if2.b !== 16'd6) begin
      n_fail++;
      $display("FAIL arst_n2_pair0: en=%b a=%0d b=%0d, want en=1 a=5 b=6", if2.en, if2.a, if2.b);
    end
    tick();
    n_tests++;
    if (if2.en !== 1'b1 || if2.a !== 16'd6 || if2.b !== 16'd5) begin
      n_fail++;
      $display("FAIL arst_n2_pair1: en=%b a=%0d b=%0d, want en=1 a=6 b=5", if2.en, if2.a, if2.b);
    end
    tick();
    tick();
  endtask

  // N_RAYS=2 with extreme values.
  task automatic test_extremes;
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    if2.dist_valid = 1'b1;
    if2.dist_in    = 16'hFFFF;
    tick();
    if2.dist_in = 16'h0000;
    tick();
    if2.dist_valid = 1'b0;
    n_tests++;
    if (if2.en !== 1'b1 || if2.a !== 16'hFFFF || if2.b !== 16'h0000) begin
      n_fail++;
      $display("FAIL ext_pair0: en=%b a=%h b=%h, want en=1 a=ffff b=0000", if2.en, if2.a, if2.b);
    end
    tick();
    n_tests++;
    if (if2.en !== 1'b1 || if2.a !== 16'h0000 || if2.b !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL ext_pair1: en=%b a=%h b=%h, want en=1 a=0000 b=ffff", if2.en, if2.a, if2.b);
    end
    tick();
    n_tests++;
    if (if2.frame_done !== 1'b1 || if2.en !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_done: fd=%b en=%b, want fd=1 en=0", if2.frame_done, if2.en);
    end
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_basic();
    do_reset();
    test_gaps();
    do_reset();
    test_overrun();
    do_reset();
    test_start_ignored();
    do_reset();
    test_async_reset();
    do_reset();
    test_extremes();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ray_pair_feeder.md
RAY_PAIR_FEEDER -- requirements
Module: ray_pair_feeder

Interface
REQ-001 Parameter N_RAYS, default 64, meaning: number of distance samples (rays) per revolution; legal range 2..1024.
REQ-002 Parameter DW, default 16, meaning: distance sample width in bits.
REQ-003 Port clk  input  1  meaning: single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  meaning: reset, asynchronous and active-high.
REQ-005 Port start  input  1  meaning: one-cycle request to begin a new revolution.
REQ-006 Port dist_valid  input  1  meaning: dist_in carries a valid sample this cycle.
REQ-007 Port dist_in  input  DW  meaning: unsigned ray distance sample.
REQ-008 Port a  output  DW  meaning: first side of the current triangle (registered).
REQ-009 Port b  output  DW  meaning: second side of the current triangle (registered).
REQ-010 Port en  output  1  meaning: one-cycle strobe; a/b valid for the downstream triangle-surface stage.
REQ-011 Port busy  output  1  meaning: revolution in progress.
REQ-012 Port frame_done  output  1  meaning: one-cycle pulse after the last pair of a revolution is issued.
REQ-013 Port overrun  output  1  meaning: sticky flag; a sample arrived while it could not be accepted inside a revolution.

Function
REQ-014 The block SHALL implement the states IDLE, FIRST, STREAM, CLOSE and DONE.
REQ-015 IDLE: busy=0; start=1 -> FIRST, clear overrun; dist_valid ignored with no flag.
REQ-016 FIRST: busy=1; on dist_valid, store the sample in first_reg and prev_reg, set cnt=1 -> STREAM; no en.
REQ-017 STREAM: on dist_valid, register a<=prev_reg, b<=dist_in, en<=1, prev_reg<=dist_in, cnt<=cnt+1.
REQ-018 STREAM: when the accepted sample is the N_RAYS-th (cnt==N_RAYS-1 before increment) -> CLOSE.
REQ-019 CLOSE: one cycle, unconditional; a<=prev_reg (last sample), b<=first_reg, en<=1 -> DONE.
REQ-020 DONE: one cycle; frame_done=1, busy still 1 -> IDLE.
REQ-021 Latency SHALL be exactly 1 clock from an accepted dist_valid to the matching en.
REQ-022 Each revolution SHALL produce exactly N_RAYS en pulses; the last closes the ring (sample N-1, sample 0).
REQ-023 en SHALL be high for exactly one cycle per pair; a and b SHALL hold their values until the next en.
REQ-024 Gaps (dist_valid=0) in FIRST/STREAM SHALL stall with no timeout and no en.
REQ-025 dist_valid in CLOSE or DONE SHALL drop the sample and set overrun.
REQ-026 start while busy=1 SHALL be ignored and does not restart the revolution.
REQ-027 Samples are passed unmodified (no saturation, zero allowed); cnt width SHALL be clog2(N_RAYS+1).
REQ-028 frame_done and en SHALL never be high in the same cycle.

Reset
REQ-029 On rst=1, state SHALL go to IDLE immediately, regardless of clock.
REQ-030 On rst=1, outputs SHALL be a=0, b=0, en=0, busy=0, frame_done=0, overrun=0; cnt, first_reg and prev_reg cleared.
REQ-031 rst mid-revolution SHALL abandon the partial revolution; no closing pair and no frame_done are issued.
REQ-032 After rst deassertion the block SHALL require a new start before accepting samples.

Verification
REQ-033 N_RAYS=4; start, then samples 10,20,30,40 on consecutive cycles -> en pairs (10,20),(20,30),(30,40),(40,10), then frame_done 1 cycle after the last en, then busy=0.
REQ-034 N_RAYS=64; 64 samples with random 0..3-cycle gaps -> exactly 64 en pulses; each en exactly 1 cycle after its sample; last pair (d63,d0).
REQ-035 N_RAYS=4; samples 1,2,3,4, with dist_valid=1 also asserted in the CLOSE cycle -> closing pair (4,1), overrun=1 until the next start, which clears it.
REQ-036 Assert start again after the 2nd sample -> ignored; pairs continue unchanged; dist_valid while in IDLE -> no en, overrun stays 0.
REQ-037 Assert rst asynchronously after the 3rd of 64 samples -> all outputs 0 within the same cycle; no frame_done; a new start plus samples 5,6 with N_RAYS=2 -> pairs (5,6),(6,5).
REQ-038 N_RAYS=2; samples 0xFFFF,0x0000 -> pairs (0xFFFF,0x0000),(0x0000,0xFFFF), values unmodified.
